// File: rtl/bsg_wormhole_test_link_arbiter.sv
// Packet-level round-robin arbiter sharing one ready/valid wormhole link among num_req_p clients.
// Latency: one IDLE arbitration cycle per packet, then flits pass combinationally from the grantee.
// Backpressure: link_ready_and_i low freezes state, count and grant; yumi is only raised on a transfer.
// Optional per-requester completed-packet counters are enabled by defining BSG_WORMHOLE_ARB_STATS_EN.
module bsg_wormhole_test_link_arbiter #(
    parameter int flit_width_p = 32,
    parameter int cord_width_p = 5,
    parameter int len_width_p  = 4,
    parameter int num_req_p    = 2
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p*flit_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]              req_yumi_o,
    output logic                              link_v_o,
    output logic [flit_width_p-1:0]           link_data_o,
    input  logic                              link_ready_and_i,
    output logic [num_req_p-1:0]              grant_o,
    output logic                              busy_o
`ifdef BSG_WORMHOLE_ARB_STATS_EN
    ,
    output logic [num_req_p*16-1:0]           pkt_count_o
`endif
);

    localparam int idx_width_lp = $clog2(num_req_p);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [num_req_p-1:0]    grant_q, grant_d;
    logic [idx_width_lp-1:0] gidx_q, gidx_d;
    logic [idx_width_lp-1:0] rr_ptr_q, rr_ptr_d;
    logic [len_width_p-1:0]  count_q, count_d;

    logic                    xfer;
    logic                    last_flit;
    logic [len_width_p-1:0]  hdr_len;
    logic                    win_found;
    logic [idx_width_lp-1:0] win_idx;
    logic [idx_width_lp:0]   cand;
    logic [idx_width_lp-1:0] cand_idx;

    // Datapath: the grantee's flit is forwarded only while a packet is locked.
    always_comb begin
        link_data_o = req_data_i[gidx_q*flit_width_p +: flit_width_p];
        link_v_o    = (state_q != IDLE) & req_v_i[gidx_q];
        xfer        = link_v_o & link_ready_and_i;
        req_yumi_o  = xfer ? grant_q : '0;
        grant_o     = grant_q;
        busy_o      = (state_q != IDLE);
        hdr_len     = link_data_o[cord_width_p +: len_width_p];
        last_flit   = xfer & (((state_q == HDR) && (hdr_len == '0)) ||
                              ((state_q == BODY) && (count_q == len_width_p'(1))));
    end

    // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo num_req_p.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        cand_idx  = '0;
        for (int k = 0; k < num_req_p; k++) begin
            cand = {1'b0, rr_ptr_q} + (idx_width_lp+1)'(k);
            if (cand >= (idx_width_lp+1)'(num_req_p)) begin
                cand = cand - (idx_width_lp+1)'(num_req_p);
            end
            cand_idx = cand[idx_width_lp-1:0];
            if (!win_found && req_v_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state logic: lock a grantee in IDLE, release it after the packet's final flit.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d  = {{(num_req_p-1){1'b0}}, 1'b1} << win_idx;
                    gidx_d   = win_idx;
                    rr_ptr_d = (win_idx == idx_width_lp'(num_req_p-1)) ? '0 : win_idx + 1'b1;
                    state_d  = HDR;
                end
            end
            HDR: begin
                if (xfer) begin
                    if (hdr_len == '0) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end else begin
                        state_d = BODY;
                        count_d = hdr_len;
                    end
                end
            end
            BODY: begin
                if (xfer) begin
                    count_d = count_q - 1'b1;
                    if (count_q == len_width_p'(1)) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset abandons any partial packet and restarts arbitration at requester 0.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef BSG_WORMHOLE_ARB_STATS_EN
    logic [15:0] pkt_cnt_q [num_req_p];

    // Completed-packet counters bump on each packet's final flit and wrap at 16 bits.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_req_p; i++) begin
                pkt_cnt_q[i] <= '0;
            end
        end else if (last_flit) begin
            pkt_cnt_q[gidx_q] <= pkt_cnt_q[gidx_q] + 16'd1;
        end
    end

    // Flatten counters onto the output bus, requester 0 in the low bits.
    always_comb begin
        pkt_count_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            pkt_count_o[i*16 +: 16] = pkt_cnt_q[i];
        end
    end
`else
    logic unused_last_flit;

    // Final-flit pulse only feeds the optional counters.
    always_comb begin
        unused_last_flit = last_flit;
    end
`endif

endmodule

// File: tb/tb_bsg_wormhole_test_link_arbiter.sv
// Bench for the packet round-robin link arbiter: client queues, packet-level reference model.
// Flit layout used here: [31:24] source, [23:16] tag, [8:5] len (headers), [4:0] cord.
// Outputs are compared against the model on every falling edge while checking is enabled.
module tb_bsg_wormhole_test_link_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_v;
    logic [63:0] req_data;
    logic [1:0]  req_yumi;
    logic        link_v;
    logic [31:0] link_data;
    logic        link_ready;
    logic [1:0]  grant;
    logic        busy;
`ifdef BSG_WORMHOLE_ARB_STATS_EN
    logic [31:0] pkt_count;
`endif

    always #5 clk = ~clk;

    bsg_wormhole_test_link_arbiter #(
        .flit_width_p(32), .cord_width_p(5), .len_width_p(4), .num_req_p(2)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .req_v_i         (req_v),
        .req_data_i      (req_data),
        .req_yumi_o      (req_yumi),
        .link_v_o        (link_v),
        .link_data_o     (link_data),
        .link_ready_and_i(link_ready),
        .grant_o         (grant),
        .busy_o          (busy)
`ifdef BSG_WORMHOLE_ARB_STATS_EN
        ,
        .pkt_count_o     (pkt_count)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [31:0] cq [2][$];
    logic        rdy_tb = 1'b1;
    logic        check_en = 1'b0;

    int owner = -1;
    int flits_left = 0;
    int ptr = 0;

    logic [1:0] s_yumi = '0;
    logic [1:0] s_pend = '0;
    logic       s_exp_xfer = 1'b0;

    int          log_src [$];
    logic [31:0] log_dat [$];
    int          log_cyc [$];
    int          g01_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] hdr_flit(input int src, input int len, input int tag);
        return {8'(src), 8'(tag), 7'd0, 4'(len), 5'd3};
    endfunction

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            req_v[i] = (cq[i].size() > 0);
            req_data[i*32 +: 32] = (cq[i].size() > 0) ? cq[i][0] : 32'd0;
        end
        link_ready = rdy_tb;
    endtask

    task automatic push_pkt(input int src, input int len, input int tag);
        cq[src].push_back(hdr_flit(src, len, tag));
        for (int j = 1; j <= len; j++) begin
            cq[src].push_back({8'(src), 8'(tag), 16'(j)});
        end
        drive();
    endtask

    // Reference compare on the falling edge: what the link must show given the locked owner.
    always @(negedge clk) begin : compare
        logic        ev;
        logic [1:0]  eg;
        logic [31:0] ed;
        ev = 1'b0;
        eg = 2'b00;
        ed = 32'd0;
        if (owner >= 0) begin
            eg = 2'b01 << owner;
            if (cq[owner].size() > 0) begin
                ev = 1'b1;
                ed = cq[owner][0];
            end
        end
        s_yumi = req_yumi;
        s_pend = req_v;
        s_exp_xfer = ev && rdy_tb;
        if (check_en) begin
            chk("link_v", link_v, ev);
            chk("grant", grant, eg);
            chk("busy", busy, owner >= 0);
            chk("yumi", req_yumi, (ev && rdy_tb) ? eg : 2'b00);
            if (ev) chk("link_data", link_data, ed);
        end
        if (link_v && link_ready) begin
            log_src.push_back(int'(link_data[31:24]));
            log_dat.push_back(link_data);
            log_cyc.push_back(cyc);
        end
        if (grant == 2'b01) g01_cnt++;
    end

    // One clock: advance the packet-level model and the clients, then redrive inputs.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (owner < 0) begin
            if (s_pend != 2'b00) begin
                for (int k = 0; k < 2; k++) begin
                    int c;
                    c = (ptr + k) % 2;
                    if (owner < 0 && s_pend[c]) owner = c;
                end
                ptr = (owner + 1) % 2;
                flits_left = int'(cq[owner][0][8:5]) + 1;
            end
        end else if (s_exp_xfer) begin
            flits_left--;
            if (flits_left == 0) owner = -1;
        end
        for (int i = 0; i < 2; i++) begin
            if (s_yumi[i] && cq[i].size() > 0) void'(cq[i].pop_front());
        end
        drive();
    endtask

    task automatic reset_model();
        owner = -1;
        flits_left = 0;
        ptr = 0;
        s_yumi = '0;
        s_pend = '0;
        s_exp_xfer = 1'b0;
    endtask

    // Asynchronous reset: outputs must fall without a clock edge, clients are reset too.
    task automatic do_reset();
        check_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst link_v", link_v, 0);
        chk("rst grant", grant, 0);
        chk("rst busy", busy, 0);
        chk("rst yumi", req_yumi, 0);
        cq[0].delete();
        cq[1].delete();
        rdy_tb = 1'b1;
        drive();
        reset_model();
        repeat (2) cycle();
        reset_model();
        reset_n = 1'b1;
        log_src.delete();
        log_dat.delete();
        log_cyc.delete();
        g01_cnt = 0;
        check_en = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((owner >= 0 || cq[0].size() > 0 || cq[1].size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        chk({name, " drained"}, n < budget, 1);
    endtask

    task automatic wait_mid(input string name, input int left, input int budget);
        int n;
        n = 0;
        while (!(owner == 0 && flits_left == left) && n < budget) begin
            cycle();
            n++;
        end
        chk({name, " reached"}, n < budget, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n0;
        logic [31:0] hold;
        int exp_src [12];
        logic [31:0] exp_t1 [4];
        reset_n = 1'b0;
        req_v = '0;
        req_data = '0;
        link_ready = 1'b1;

        // Test 1: single len=3 packet from requester 0, then a maximum-length packet.
        do_reset();
        push_pkt(0, 3, 1);
        drain("t1", 50);
        chk("t1 busy after", busy, 0);
        chk("t1 flit count", log_dat.size(), 4);
        chk("t1 grant01 cycles", g01_cnt, 4);
        exp_t1 = '{32'h00010063, 32'h00010001, 32'h00010002, 32'h00010003};
        for (int i = 0; i < 4; i++) begin
            if (i < log_dat.size()) chk("t1 flit", log_dat[i], exp_t1[i]);
        end
        push_pkt(0, 15, 2);
        drain("t1 max", 60);
        chk("t1 max count", log_dat.size(), 20);
        if (log_dat.size() == 20) begin
            chk("t1 max hdr", log_dat[4], 32'h000201E3);
            chk("t1 max last", log_dat[19], 32'h0002000F);
        end

        // Test 2: both requesters busy with len=1 packets; grants alternate, no interleave.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            push_pkt(0, 1, 16 + p);
            push_pkt(1, 1, 32 + p);
        end
        drain("t2", 100);
        exp_src = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
        chk("t2 flit count", log_src.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < log_src.size()) chk("t2 src order", log_src[i], exp_src[i]);
        end
        if (log_cyc.size() >= 3) chk("t2 pkt period", log_cyc[2] - log_cyc[0], 3);

        // Test 3: len=0 packets from requester 1 take 2 cycles; pointer wraps back to 0.
        do_reset();
        for (int p = 0; p < 3; p++) push_pkt(1, 0, 48 + p);
        drain("t3", 50);
        chk("t3 flit count", log_cyc.size(), 3);
        if (log_cyc.size() == 3) begin
            chk("t3 period a", log_cyc[1] - log_cyc[0], 2);
            chk("t3 period b", log_cyc[2] - log_cyc[1], 2);
        end
        push_pkt(0, 0, 60);
        push_pkt(1, 0, 61);
        drain("t3 wrap", 50);
        if (log_src.size() == 5) begin
            chk("t3 wrap first", log_src[3], 0);
            chk("t3 wrap second", log_src[4], 1);
        end else begin
            chk("t3 wrap count", log_src.size(), 5);
        end

        // Test 4: stall for 5 cycles mid-body with two body flits left.
        do_reset();
        push_pkt(0, 4, 5);
        wait_mid("t4", 2, 30);
        rdy_tb = 1'b0;
        drive();
        #1;
        hold = link_data;
        chk("t4 stall data", hold, 32'h00050003);
        repeat (5) begin
            cycle();
            chk("t4 data stable", link_data, 32'h00050003);
            chk("t4 yumi low", req_yumi, 0);
        end
        n0 = log_dat.size();
        rdy_tb = 1'b1;
        drive();
        drain("t4", 30);
        chk("t4 remaining xfers", log_dat.size() - n0, 2);

        // Test 5: asynchronous reset mid-body, then arbitration restarts at requester 0.
        do_reset();
        push_pkt(0, 5, 7);
        push_pkt(1, 1, 8);
        wait_mid("t5", 3, 30);
        #2;
        do_reset();
        push_pkt(0, 0, 9);
        push_pkt(1, 0, 10);
        drain("t5", 30);
        chk("t5 flit count", log_src.size(), 2);
        if (log_src.size() > 0) chk("t5 first src", log_src[0], 0);

`ifdef BSG_WORMHOLE_ARB_STATS_EN
        // Test 6: packet counters, including 16-bit wrap.
        do_reset();
        push_pkt(0, 0, 1);
        push_pkt(0, 1, 2);
        push_pkt(0, 2, 3);
        push_pkt(1, 1, 4);
        push_pkt(1, 0, 5);
        drain("t6", 100);
        chk("t6 pkt_count", pkt_count, {16'd2, 16'd3});
        dut.pkt_cnt_q[0] = 16'hFFFF;
        push_pkt(0, 0, 6);
        drain("t6 wrap", 20);
        chk("t6 wrap req0", pkt_count[15:0], 16'd0);
        chk("t6 wrap req1", pkt_count[31:16], 16'd2);
`endif

        repeat (2) cycle();
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
